// File: rtl/uzorak_sakupljac.sv
`default_nettype none
// ============================================================================
//  Module      : uzorak_sakupljac
//  Description : Collects SIRINA-bit samples from a valid/ready stream into a
//                BROJ_UZORAKA-slot vector (uzorak) that feeds a combinational
//                neuron. Once the vector is full it is held stable for
//                SETTLE_CYCLES edges. The neuron output is then registered and
//                offered downstream over a valid/ready handshake.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                ulaz_podatak/valid  - incoming sample stream
//                ulaz_ready          - high while the frame is being filled
//                odbaci              - abort current frame (ignored in output)
//                uzorak              - packed vector, slot k at [16k+15:16k]
//                neuron_izlaz        - combinational neuron result from uzorak
//                rezultat/_valid     - registered result and its valid flag
//                rezultat_ready      - downstream accepts rezultat
//                broj_primljenih     - samples accepted in the current frame
//  Revision    : 1.0 - initial release
// ============================================================================
module uzorak_sakupljac #(
    parameter int BROJ_UZORAKA  = 60,
    parameter int SIRINA        = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SIRINA-1:0]                ulaz_podatak,
    input  logic                             ulaz_valid,
    output logic                             ulaz_ready,
    input  logic                             odbaci,
    output logic [BROJ_UZORAKA*SIRINA-1:0]   uzorak,
    input  logic [SIRINA-1:0]                neuron_izlaz,
    output logic [SIRINA-1:0]                rezultat,
    output logic                             rezultat_valid,
    input  logic                             rezultat_ready,
    output logic [5:0]                       broj_primljenih
);

    typedef enum logic [1:0] {
        PUNJENJE = 2'd0,
        CEKANJE  = 2'd1,
        IZLAZ    = 2'd2
    } stanje_t;

    localparam logic [5:0] c_ZADNJI      = 6'(BROJ_UZORAKA - 1);
    // The counter reaches zero SETTLE_CYCLES-1 edges after loading, so the
    // capture edge lands exactly SETTLE_CYCLES edges after the last write.
    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    stanje_t                           r_stanje;
    stanje_t                           w_stanje_next;
    logic [5:0]                        r_broj;
    logic [3:0]                        r_settle;
    logic [BROJ_UZORAKA*SIRINA-1:0]    r_uzorak;
    logic [SIRINA-1:0]                 r_rezultat;
    logic                              r_rezultat_valid;

    logic                              w_upis;     // sample transfer this edge
    logic                              w_hvat;     // capture neuron output
    logic                              w_predaja;  // downstream handshake
    logic                              w_ponisti;  // effective abort

    // Next-state and per-edge action decode
    always_comb begin
        w_stanje_next = r_stanje;
        w_upis        = 1'b0;
        w_hvat        = 1'b0;
        w_predaja     = 1'b0;
        w_ponisti     = 1'b0;
        case (r_stanje)
            PUNJENJE: begin
                if (odbaci) begin
                    // Abort wins over a simultaneous sample; it is dropped
                    w_ponisti = 1'b1;
                end else if (ulaz_valid) begin
                    w_upis = 1'b1;
                    if (r_broj == c_ZADNJI) begin
                        w_stanje_next = CEKANJE;
                    end
                end
            end
            CEKANJE: begin
                if (odbaci) begin
                    w_ponisti     = 1'b1;
                    w_stanje_next = PUNJENJE;
                end else if (r_settle == 4'd0) begin
                    w_hvat        = 1'b1;
                    w_stanje_next = IZLAZ;
                end
            end
            IZLAZ: begin
                // Abort is ignored here: the result must be consumed
                if (rezultat_ready) begin
                    w_predaja     = 1'b1;
                    w_stanje_next = PUNJENJE;
                end
            end
            default: begin
                w_stanje_next = PUNJENJE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stanje <= PUNJENJE;
        end else begin
            r_stanje <= w_stanje_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_broj           <= 6'd0;
            r_settle         <= 4'd0;
            r_uzorak         <= '0;
            r_rezultat       <= '0;
            r_rezultat_valid <= 1'b0;
        end else begin
            if (w_ponisti || w_predaja) begin
                r_broj <= 6'd0;
            end else if (w_upis) begin
                r_broj <= r_broj + 6'd1;
            end

            // Unwritten slots keep the previous frame's data on purpose
            if (w_upis) begin
                r_uzorak[r_broj*SIRINA +: SIRINA] <= ulaz_podatak;
            end

            if (w_upis && (r_broj == c_ZADNJI)) begin
                r_settle <= c_SETTLE_LOAD;
            end else if ((r_stanje == CEKANJE) && (r_settle != 4'd0)) begin
                r_settle <= r_settle - 4'd1;
            end

            if (w_hvat) begin
                r_rezultat       <= neuron_izlaz;
                r_rezultat_valid <= 1'b1;
            end else if (w_predaja) begin
                r_rezultat_valid <= 1'b0;
            end
        end
    end

    assign ulaz_ready      = (r_stanje == PUNJENJE);
    assign uzorak          = r_uzorak;
    assign rezultat        = r_rezultat;
    assign rezultat_valid  = r_rezultat_valid;
    assign broj_primljenih = r_broj;

endmodule
`default_nettype wire

// File: tb/tb_uzorak_sakupljac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uzorak_sakupljac
//  Description : Self-checking bench. dut0 uses SETTLE_CYCLES=2, dut1 uses
//                SETTLE_CYCLES=1. A frame-level model tracks the expected
//                outputs of both and is compared every cycle; directed
//                sequences add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uzorak_sakupljac;

    localparam int N  = 60;
    localparam int W  = 16;
    localparam int VW = N * W;
    localparam int M_FILL   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_OUT    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0 (settle 2)
    logic          rst0, v0, ab0, rr0, rdy0, rv0;
    logic [W-1:0]  d0, nz0, rez0;
    logic [VW-1:0] uz0;
    logic [5:0]    cnt0;
    // dut1 (settle 1)
    logic          rst1, v1, ab1, rr1, rdy1, rv1;
    logic [W-1:0]  d1, nz1, rez1;
    logic [VW-1:0] uz1;
    logic [5:0]    cnt1;

    int n_cmp = 0;
    int n_err = 0;

    // Stand-in neuron: position-weighted sum, so slot order matters
    function automatic logic [W-1:0] neuron(input logic [VW-1:0] v);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc = acc + 16'((k + 1) * int'(v[16*k +: 16]));
        end
        return acc;
    endfunction

    assign nz0 = neuron(uz0);
    assign nz1 = neuron(uz1);

    uzorak_sakupljac #(.BROJ_UZORAKA(N), .SIRINA(W), .SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst0), .ulaz_podatak(d0), .ulaz_valid(v0),
        .ulaz_ready(rdy0), .odbaci(ab0), .uzorak(uz0), .neuron_izlaz(nz0),
        .rezultat(rez0), .rezultat_valid(rv0), .rezultat_ready(rr0),
        .broj_primljenih(cnt0)
    );

    uzorak_sakupljac #(.BROJ_UZORAKA(N), .SIRINA(W), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .ulaz_podatak(d1), .ulaz_valid(v1),
        .ulaz_ready(rdy1), .odbaci(ab1), .uzorak(uz1), .neuron_izlaz(nz1),
        .rezultat(rez1), .rezultat_valid(rv1), .rezultat_ready(rr1),
        .broj_primljenih(cnt1)
    );

    // ---------------- frame-level model ----------------
    logic [W-1:0] m_slot  [2][N];
    logic [W-1:0] m_rez   [2];
    bit           m_rv    [2];
    int           m_cnt   [2];
    int           m_mode  [2];
    int           m_since [2];
    bit           m_live  [2];

    function automatic logic [VW-1:0] m_vec(input int d);
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[16*k +: 16] = m_slot[d][k];
        return v;
    endfunction

    task automatic step(input int d, input int settle, input bit r, input bit v,
                        input bit ab, input bit rr, input logic [W-1:0] x);
        if (r) begin
            for (int k = 0; k < N; k++) m_slot[d][k] = '0;
            m_rez[d] = '0; m_rv[d] = 0; m_cnt[d] = 0;
            m_mode[d] = M_FILL; m_since[d] = 0; m_live[d] = 1;
        end else if (m_live[d]) begin
            if (m_mode[d] == M_FILL) begin
                if (ab) begin
                    m_cnt[d] = 0;
                end else if (v) begin
                    m_slot[d][m_cnt[d]] = x;
                    m_cnt[d]++;
                    if (m_cnt[d] == N) begin
                        m_mode[d] = M_SETTLE; m_since[d] = 0;
                    end
                end
            end else if (m_mode[d] == M_SETTLE) begin
                if (ab) begin
                    m_mode[d] = M_FILL; m_cnt[d] = 0;
                end else begin
                    m_since[d]++;
                    if (m_since[d] == settle) begin
                        m_rez[d] = neuron(m_vec(d)); m_rv[d] = 1; m_mode[d] = M_OUT;
                    end
                end
            end else begin
                if (rr) begin
                    m_rv[d] = 0; m_cnt[d] = 0; m_mode[d] = M_FILL;
                end
            end
        end
    endtask

    initial begin
        m_live[0] = 0;
        m_live[1] = 0;
    end

    always @(posedge clk) begin
        step(0, 2, rst0, v0, ab0, rr0, d0);
        step(1, 1, rst1, v1, ab1, rr1, d1);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input int d, input logic [VW-1:0] act,
                           input logic [VW-1:0] exp);
        int bad;
        bad = -1;
        n_cmp++;
        for (int k = N - 1; k >= 0; k--) begin
            if (act[16*k +: 16] !== exp[16*k +: 16]) bad = k;
        end
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s dut%0d: slot %0d got %h, expected %h (t=%0t)", name, d, bad,
                     act[16*bad +: 16], exp[16*bad +: 16], $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_live[d]) begin
                chk("ulaz_ready", d, 32'(d == 0 ? rdy0 : rdy1), 32'(m_mode[d] == M_FILL));
                chk("broj",       d, 32'(d == 0 ? cnt0 : cnt1), 32'(m_cnt[d]));
                chk("rez_valid",  d, 32'(d == 0 ? rv0 : rv1),   32'(m_rv[d]));
                chk("rezultat",   d, 32'(d == 0 ? rez0 : rez1), 32'(m_rez[d]));
                chk_vec("uzorak", d, (d == 0 ? uz0 : uz1), m_vec(d));
            end
        end
    end

    // Feed n samples base, base+1, ... into dut0; ends on the negedge after
    // the last accept edge with ulaz_valid dropped.
    task automatic stream(input int n, input logic [W-1:0] base, input bit gap);
        int i;
        int guard;
        bit ph;
        i = 0; guard = 0; ph = 0;
        while (i < n && guard < 4 * n + 10) begin
            @(negedge clk);
            guard++;
            if (gap && ph) begin
                v0 = 1'b0;
            end else begin
                v0 = 1'b1;
                d0 = base + 16'(i);
                if (rdy0) i++;
            end
            ph = ~ph;
        end
        if (i < n) begin
            n_cmp++; n_err++;
            $display("FAIL stream_timeout: accepted %0d, required %0d", i, n);
        end
        @(negedge clk);
        v0 = 1'b0;
    endtask

    logic [VW-1:0] exp_a;
    int first_rv, hs;

    initial begin
        for (int k = 0; k < N; k++) exp_a[16*k +: 16] = 16'h0100 + 16'(k);
        rst0 = 1; v0 = 0; ab0 = 0; rr0 = 1; d0 = '0;
        rst1 = 1; v1 = 0; ab1 = 0; rr1 = 1; d1 = '0;
        repeat (2) @(negedge clk);
        rst0 = 0;
        chk("rst_uz_zero", 0, 32'(uz0 == '0), 32'd1);
        chk("rst_rv",      0, 32'(rv0), 32'd0);
        chk("rst_rez",     0, 32'(rez0), 32'd0);
        chk("rst_broj",    0, 32'(cnt0), 32'd0);
        chk("rst_ready",   0, 32'(rdy0), 32'd1);

        // Frame A: back-to-back samples, downstream always ready
        stream(N, 16'h0100, 1'b0);
        chk("A_ready_low", 0, 32'(rdy0), 32'd0);
        chk("A_broj60",    0, 32'(cnt0), 32'd60);
        @(negedge clk);
        chk("A_rv_e0p1",   0, 32'(rv0), 32'd0);
        @(negedge clk);
        chk("A_rv_e0p2",   0, 32'(rv0), 32'd1);
        chk("A_rez",       0, 32'(rez0), 32'h3F2C);
        chk("A_slot0",     0, 32'(uz0[15:0]), 32'h0100);
        chk("A_slot59",    0, 32'(uz0[959:944]), 32'h013B);
        @(negedge clk);
        chk("A_ready_after", 0, 32'(rdy0), 32'd1);
        chk("A_rv_after",    0, 32'(rv0), 32'd0);

        // Frame B: gapped input, result held under backpressure
        rr0 = 0;
        stream(N, 16'h0100, 1'b1);
        chk_vec("B_vec", 0, uz0, exp_a);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("B_rv_hold",    0, 32'(rv0), 32'd1);
            chk("B_rez_hold",   0, 32'(rez0), 32'h3F2C);
            chk("B_ready_hold", 0, 32'(rdy0), 32'd0);
            chk_vec("B_vec_hold", 0, uz0, exp_a);
            ab0 = (i == 5);
            @(negedge clk);
        end
        ab0 = 0; rr0 = 1;
        @(negedge clk);
        rr0 = 0;
        chk("B_rv_taken", 0, 32'(rv0), 32'd0);
        chk("B_broj0",    0, 32'(cnt0), 32'd0);
        @(negedge clk);
        chk("B_single",   0, 32'(rv0), 32'd0);

        // Frame C: abort at 30 with a simultaneous sample
        stream(30, 16'h0500, 1'b0);
        chk("C_broj30", 0, 32'(cnt0), 32'd30);
        v0 = 1; d0 = 16'hDEAD; ab0 = 1;
        @(negedge clk);
        v0 = 0; ab0 = 0;
        chk("C_broj0",   0, 32'(cnt0), 32'd0);
        chk("C_slot30",  0, 32'(uz0[16*30 +: 16]), 32'h011E);
        chk("C_slot0",   0, 32'(uz0[15:0]), 32'h0500);
        stream(1, 16'h0777, 1'b0);
        chk("C_new0",    0, 32'(uz0[15:0]), 32'h0777);
        chk("C_broj1",   0, 32'(cnt0), 32'd1);
        chk("C_no_rv",   0, 32'(rv0), 32'd0);

        // Complete the frame, then reset while settling
        stream(N - 1, 16'h0900, 1'b0);
        rst0 = 1;
        @(negedge clk);
        rst0 = 0;
        chk("R_rv",    0, 32'(rv0), 32'd0);
        chk_vec("R_uz", 0, uz0, '0);
        chk("R_broj",  0, 32'(cnt0), 32'd0);
        chk("R_ready", 0, 32'(rdy0), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("R_no_result", 0, 32'(rv0), 32'd0);
        end

        // dut1: two back-to-back frames with settle of one cycle
        first_rv = -1; hs = 0;
        rst1 = 0; v1 = 1; d1 = 16'h0201; rr1 = 1;
        for (int e = 1; e <= 2 * (N + 2); e++) begin
            @(negedge clk);
            if (rv1) begin
                hs++;
                if (first_rv < 0) first_rv = e;
            end
            d1 = 16'h0201 + 16'(e);
        end
        v1 = 0;
        chk("S1_first_rv_edge", 1, 32'(first_rv), 32'd61);
        chk("S1_two_results",   1, 32'(hs), 32'd2);
        chk("S1_ready_end",     1, 32'(rdy1), 32'd1);
        chk("S1_broj_end",      1, 32'(cnt1), 32'd0);
        chk("S1_rv_end",        1, 32'(rv1), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d",
                 n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
